// File: rtl/indication_word_serializer_if.sv
// Bundle of the message-in, word-out, and status signals of the indication word serializer.
// Transfer rule: a transfer happens on a rising clk edge exactly when ena and rdy are both 1;
// a source asserts ena only while rdy=1, and payload is meaningful only when ena=1.
interface indication_word_serializer_if;
  logic         in_enq_ena;
  logic [127:0] in_enq_v;
  logic [15:0]  in_enq_length;
  logic         in_enq_rdy;

  logic         out_enq_ena;
  logic [31:0]  out_enq_v;
  logic         out_enq_last;
  logic         out_enq_rdy;

  logic         err_overlen;
  logic [15:0]  stat_msgs;

  modport slave (
    input  in_enq_ena, in_enq_v, in_enq_length, out_enq_rdy,
    output in_enq_rdy, out_enq_ena, out_enq_v, out_enq_last, err_overlen, stat_msgs
  );

  modport master (
    output in_enq_ena, in_enq_v, in_enq_length, out_enq_rdy,
    input  in_enq_rdy, out_enq_ena, out_enq_v, out_enq_last, err_overlen, stat_msgs
  );
endinterface

// File: rtl/indication_word_serializer.sv
// Buffers 128-bit indication messages in a small FIFO and streams each one out as
// 32-bit words with a last-word marker, decoupling the portal from host back-pressure.
module indication_word_serializer #(
  parameter int DEPTH = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  indication_word_serializer_if.slave    io
);

  localparam int WORDS = 4;
  localparam int AW    = $clog2(DEPTH);
  localparam int PW    = AW + 1;

  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic [127:0]   mem_v   [DEPTH];
  logic [2:0]     mem_len [DEPTH];

  logic           run_q;
  logic [1:0]     widx;
  logic           err_q;
  logic [15:0]    msgs_q;

  logic           empty;
  logic           full;
  logic [127:0]   head_v;
  logic [2:0]     head_len;
  logic [2:0]     len_clamped;
  logic           overlen;
  logic           valid;
  logic           is_last;
  logic           beat;
  logic           push;
  logic           pop;
  logic [31:0]    word;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign head_v   = mem_v[rd_ptr[AW-1:0]];
  assign head_len = mem_len[rd_ptr[AW-1:0]];

  // Over-length messages are still sent, truncated to the slot width.
  assign overlen     = (io.in_enq_length > 16'(WORDS));
  assign len_clamped = overlen ? 3'(WORDS) : io.in_enq_length[2:0];

  assign valid   = !empty && (head_len != 3'd0);
  assign is_last = valid && ({1'b0, widx} == (head_len - 3'd1));
  assign beat    = valid && io.out_enq_rdy;
  assign push    = io.in_enq_ena && io.in_enq_rdy;
  // Zero-length entries carry no words; drop them as soon as they reach the head.
  assign pop     = (beat && is_last) || (!empty && (head_len == 3'd0));
  assign word    = head_v[32*int'(widx) +: 32];

  assign io.in_enq_rdy   = run_q && !full;
  assign io.out_enq_ena  = beat;
  assign io.out_enq_v    = valid ? word : 32'd0;
  assign io.out_enq_last = is_last;
  assign io.err_overlen  = err_q;
  assign io.stat_msgs    = msgs_q;

  // Payload storage needs no reset: nothing is visible until the pointers say so.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_v[wr_ptr[AW-1:0]]   <= io.in_enq_v;
      mem_len[wr_ptr[AW-1:0]] <= len_clamped;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q  <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      widx   <= 2'd0;
      err_q  <= 1'b0;
      msgs_q <= 16'd0;
    end else begin
      run_q <= 1'b1;
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
        if (overlen) begin
          err_q <= 1'b1;
        end
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      if (beat) begin
        if (is_last) begin
          widx   <= 2'd0;
          msgs_q <= msgs_q + 16'd1;
        end else begin
          widx <= widx + 2'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_indication_word_serializer.sv
// Directed bench for indication_word_serializer: step-by-step checks plus a beat scoreboard.
module tb_indication_word_serializer;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  logic [32:0] exp_q[$];

  indication_word_serializer_if bus ();

  indication_word_serializer #(.DEPTH(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (bus.slave)
  );

  // Clock / watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [127:0] v, input logic [15:0] len);
    int n;
    n = (len > 16'd4) ? 4 : int'(len);
    for (int k = 0; k < n; k++) begin
      exp_q.push_back({(k == n - 1), v[32*k +: 32]});
    end
    check("push_rdy", 128'(bus.in_enq_rdy), 128'(1));
    bus.in_enq_ena    = 1'b1;
    bus.in_enq_v      = v;
    bus.in_enq_length = len;
    tick();
    bus.in_enq_ena    = 1'b0;
    bus.in_enq_v      = '0;
    bus.in_enq_length = '0;
  endtask

  task automatic check_out(input string tag, input logic ena, input logic [31:0] v, input logic last);
    check({tag, "_ena"},  128'(bus.out_enq_ena),  128'(ena));
    check({tag, "_v"},    128'(bus.out_enq_v),    128'(v));
    check({tag, "_last"}, 128'(bus.out_enq_last), 128'(last));
  endtask

  // Scoreboard: every beat must match the next expected word, in order.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
    end else if (bus.out_enq_ena) begin
      check("beat_expected", 128'(exp_q.size() != 0), 128'(1));
      if (exp_q.size() != 0) begin
        check("beat_word", 128'({bus.out_enq_last, bus.out_enq_v}), 128'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    logic [31:0] hv;
    logic        hl;
    logic        hold;
    int          beats;

    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    bus.in_enq_ena    = 1'b0;
    bus.in_enq_v      = '0;
    bus.in_enq_length = '0;
    bus.out_enq_rdy   = 1'b0;

    // Reset state
    #1;
    check("rst_in_rdy", 128'(bus.in_enq_rdy), 128'(0));
    check_out("rst", 1'b0, 32'd0, 1'b0);
    check("rst_err", 128'(bus.err_overlen), 128'(0));
    check("rst_msgs", 128'(bus.stat_msgs), 128'(0));
    @(negedge clk);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    check("post_rst_in_rdy", 128'(bus.in_enq_rdy), 128'(1));

    // T1: one full 4-word message at full rate
    bus.out_enq_rdy = 1'b1;
    push(128'h44444444_33333333_22222222_11111111, 16'd4);
    check_out("t1_w0", 1'b1, 32'h11111111, 1'b0);
    tick();
    check_out("t1_w1", 1'b1, 32'h22222222, 1'b0);
    tick();
    check_out("t1_w2", 1'b1, 32'h33333333, 1'b0);
    tick();
    check_out("t1_w3", 1'b1, 32'h44444444, 1'b1);
    tick();
    check_out("t1_idle", 1'b0, 32'd0, 1'b0);
    check("t1_msgs", 128'(bus.stat_msgs), 128'(1));

    // T2: 1-word then 2-word message back to back
    push(128'h0000aaaa_0000aaaa_0000aaaa_aaaa0001, 16'd1);
    check_out("t2_b1", 1'b1, 32'haaaa0001, 1'b1);
    push(128'h00000000_00000000_bbbb0002_bbbb0001, 16'd2);
    check_out("t2_b2", 1'b1, 32'hbbbb0001, 1'b0);
    tick();
    check_out("t2_b3", 1'b1, 32'hbbbb0002, 1'b1);
    tick();
    check_out("t2_idle", 1'b0, 32'd0, 1'b0);
    check("t2_msgs", 128'(bus.stat_msgs), 128'(3));

    // T3: fill the FIFO under back-pressure, then drain
    bus.out_enq_rdy = 1'b0;
    push(128'h00000000_00000000_cccc0002_cccc0001, 16'd2);
    check("t3_rdy_one", 128'(bus.in_enq_rdy), 128'(1));
    push(128'h00000000_00000000_00000000_dddd0001, 16'd1);
    check("t3_rdy_full", 128'(bus.in_enq_rdy), 128'(0));
    check_out("t3_held", 1'b0, 32'hcccc0001, 1'b0);
    tick();
    check_out("t3_still_held", 1'b0, 32'hcccc0001, 1'b0);
    bus.out_enq_rdy = 1'b1;
    #1;
    check_out("t3_c1", 1'b1, 32'hcccc0001, 1'b0);
    tick();
    check_out("t3_c2", 1'b1, 32'hcccc0002, 1'b1);
    check("t3_rdy_at_pop", 128'(bus.in_enq_rdy), 128'(0));
    tick();
    check("t3_rdy_after_pop", 128'(bus.in_enq_rdy), 128'(1));
    check_out("t3_d1", 1'b1, 32'hdddd0001, 1'b1);
    tick();
    check_out("t3_idle", 1'b0, 32'd0, 1'b0);
    check("t3_msgs", 128'(bus.stat_msgs), 128'(5));
    check("t3_err_clear", 128'(bus.err_overlen), 128'(0));

    // T4: over-length message, then a zero-length one
    push(128'heeee0004_eeee0003_eeee0002_eeee0001, 16'd9);
    check("t4_err", 128'(bus.err_overlen), 128'(1));
    check_out("t4_w0", 1'b1, 32'heeee0001, 1'b0);
    tick();
    check_out("t4_w1", 1'b1, 32'heeee0002, 1'b0);
    tick();
    check_out("t4_w2", 1'b1, 32'heeee0003, 1'b0);
    tick();
    check_out("t4_w3", 1'b1, 32'heeee0004, 1'b1);
    tick();
    check("t4_msgs", 128'(bus.stat_msgs), 128'(6));
    push(128'hffffffff_ffffffff_ffffffff_ffffffff, 16'd0);
    check_out("t4_zero", 1'b0, 32'd0, 1'b0);
    push(128'h00000000_00000000_00000000_0000f001, 16'd1);
    check_out("t4_after_zero", 1'b1, 32'h0000f001, 1'b1);
    tick();
    check_out("t4_idle", 1'b0, 32'd0, 1'b0);
    check("t4_msgs_zero", 128'(bus.stat_msgs), 128'(7));
    check("t4_err_sticky", 128'(bus.err_overlen), 128'(1));

    // T5: random back-pressure mid-message
    push(128'h55550004_55550003_55550002_55550001, 16'd4);
    beats = 0;
    hold  = 1'b0;
    hv    = '0;
    hl    = 1'b0;
    for (int c = 0; c < 60 && beats < 4; c++) begin
      bus.out_enq_rdy = 1'($urandom_range(0, 1));
      #1;
      if (hold) begin
        check("t5_v_stable", 128'(bus.out_enq_v), 128'(hv));
        check("t5_last_stable", 128'(bus.out_enq_last), 128'(hl));
      end
      if (bus.out_enq_ena) beats++;
      hold = !bus.out_enq_ena;
      hv   = bus.out_enq_v;
      hl   = bus.out_enq_last;
      tick();
    end
    check("t5_beats", 128'(beats), 128'(4));
    check("t5_msgs", 128'(bus.stat_msgs), 128'(8));
    bus.out_enq_rdy = 1'b1;

    // T6: reset in the middle of a message
    push(128'h66660004_66660003_66660002_66660001, 16'd4);
    tick();
    tick();
    check_out("t6_w2", 1'b1, 32'h66660003, 1'b0);
    rst_n = 1'b0;
    #1;
    check_out("t6_rst", 1'b0, 32'd0, 1'b0);
    check("t6_rst_in_rdy", 128'(bus.in_enq_rdy), 128'(0));
    check("t6_rst_msgs", 128'(bus.stat_msgs), 128'(0));
    check("t6_rst_err", 128'(bus.err_overlen), 128'(0));
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    check("t6_in_rdy", 128'(bus.in_enq_rdy), 128'(1));
    check_out("t6_empty", 1'b0, 32'd0, 1'b0);
    check("t6_msgs", 128'(bus.stat_msgs), 128'(0));
    push(128'h00000000_00000000_00000000_77770001, 16'd1);
    check_out("t6_new", 1'b1, 32'h77770001, 1'b1);
    tick();
    check("t6_msgs_new", 128'(bus.stat_msgs), 128'(1));

    tick();
    check("exp_q_drained", 128'(exp_q.size()), 128'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
